// File: rtl/systolic_feeder.sv
// Loads one A and one B matrix, then sequences clear/feed/read/shift for a 5x5 output-stationary array.
// Optional FEEDER_PERF_EN adds a saturating perf_cnt of completed multiplies.
module systolic_feeder #(
    parameter int N   = 32,
    parameter int DIM = 5
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 ld_en,
    input  logic                 ld_sel,
    input  logic [2:0]           ld_row,
    input  logic [DIM*N-1:0]     ld_data,
    output logic                 ld_err,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [DIM*N-1:0]     a_out,
    output logic [DIM*N-1:0]     b_out,
    output logic [DIM*DIM-1:0]   pe_clr,
    output logic [DIM*DIM-1:0]   pe_read,
    output logic [DIM*DIM-1:0]   pe_write,
    output logic                 res_valid,
    output logic [2:0]           res_row
`ifdef FEEDER_PERF_EN
    ,
    output logic [15:0]          perf_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_READ, S_SHIFT, S_LAST
    } state_t;

    state_t       state, state_nx;
    logic [3:0]   cnt, cnt_nx;

    logic [N-1:0] mem_a [DIM][DIM];
    logic [N-1:0] mem_b [DIM][DIM];

    logic                 ld_ok, ld_err_nx, busy_nx, done_nx, rv_nx;
    logic [2:0]           row_nx;
    logic [DIM*N-1:0]     a_nx, b_nx;
    logic [DIM*DIM-1:0]   clr_nx, rd_nx, wr_nx;

    assign ld_ok     = ld_en && (state == S_IDLE) && (ld_row <= 3'd4);
    assign ld_err_nx = ld_en && ((state != S_IDLE) || (ld_row > 3'd4));

    // NOTE: the matrix stores are reset on purpose; a run after reset must see all-zero operands.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int k = 0; k < DIM; k++) begin
                    mem_a[r][k] <= '0;
                    mem_b[r][k] <= '0;
                end
            end
        end else if (ld_ok) begin
            for (int k = 0; k < DIM; k++) begin
                if (ld_sel) mem_b[ld_row][k] <= ld_data[k*N +: N];
                else        mem_a[ld_row][k] <= ld_data[k*N +: N];
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE:  if (start) begin state_nx = S_CLEAR; cnt_nx = '0; end
            S_CLEAR: begin state_nx = S_FEED; cnt_nx = '0; end
            S_FEED:  if (cnt == 4'd12) begin state_nx = S_READ; cnt_nx = '0; end
                     else cnt_nx = cnt + 4'd1;
            S_READ:  begin state_nx = S_SHIFT; cnt_nx = '0; end
            S_SHIFT: if (cnt == 4'd3) begin state_nx = S_LAST; cnt_nx = '0; end
                     else cnt_nx = cnt + 4'd1;
            S_LAST:  begin state_nx = S_IDLE; cnt_nx = '0; end
            default: begin state_nx = S_IDLE; cnt_nx = '0; end
        endcase
    end

    // Outputs are decoded from the next state so every port can come straight from a flop.
    always_comb begin
        a_nx    = '0;
        b_nx    = '0;
        clr_nx  = '0;
        rd_nx   = '0;
        wr_nx   = '0;
        rv_nx   = 1'b0;
        row_nx  = '0;
        done_nx = 1'b0;
        busy_nx = (state_nx != S_IDLE);
        case (state_nx)
            S_CLEAR: clr_nx = '1;
            S_FEED: begin
                // Element k of row/column i leaves the feeder at cycle i+k, giving the diagonal skew.
                for (int i = 0; i < DIM; i++) begin
                    for (int k = 0; k < DIM; k++) begin
                        if (int'(cnt_nx) == i + k) begin
                            a_nx[i*N +: N] = mem_a[i][k];
                            b_nx[i*N +: N] = mem_b[k][i];
                        end
                    end
                end
            end
            S_READ:  rd_nx = '1;
            S_SHIFT: begin
                wr_nx  = '1;
                rv_nx  = 1'b1;
                row_nx = 3'd4 - cnt_nx[2:0];
            end
            S_LAST: begin
                rv_nx   = 1'b1;
                done_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb blocks above use blocking.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ld_err    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            pe_clr    <= '0;
            pe_read   <= '0;
            pe_write  <= '0;
            res_valid <= 1'b0;
            res_row   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ld_err    <= ld_err_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            a_out     <= a_nx;
            b_out     <= b_nx;
            pe_clr    <= clr_nx;
            pe_read   <= rd_nx;
            pe_write  <= wr_nx;
            res_valid <= rv_nx;
            res_row   <= row_nx;
        end
    end

`ifdef FEEDER_PERF_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)                          perf_cnt <= '0;
        else if (done && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes per-cycle expectations, a monitor pops and compares.
// A small array emulation rebuilds the product from the fed lanes; define FEEDER_PERF_EN to test perf_cnt.
module tb_systolic_feeder;
    localparam int N   = 32;
    localparam int DIM = 5;

    logic               clk, clr_n, ld_en, ld_sel, start;
    logic [2:0]         ld_row;
    logic [DIM*N-1:0]   ld_data;
    logic               ld_err, busy, done, res_valid;
    logic [DIM*N-1:0]   a_out, b_out;
    logic [DIM*DIM-1:0] pe_clr, pe_read, pe_write;
    logic [2:0]         res_row;
`ifdef FEEDER_PERF_EN
    logic [15:0]        perf_cnt;
`endif

    systolic_feeder #(.N(N), .DIM(DIM)) dut (
        .clk(clk), .clr_n(clr_n), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row),
        .ld_data(ld_data), .ld_err(ld_err), .start(start), .busy(busy), .done(done),
        .a_out(a_out), .b_out(b_out), .pe_clr(pe_clr), .pe_read(pe_read),
        .pe_write(pe_write), .res_valid(res_valid), .res_row(res_row)
`ifdef FEEDER_PERF_EN
        , .perf_cnt(perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                 c;
        logic               done;
        logic [DIM*N-1:0]   a, b;
        logic [DIM*DIM-1:0] clr, rd, wr;
        logic               rv;
        logic [2:0]         row;
    } exp_t;

    exp_t                   exp_q[$];
    logic [DIM*DIM*N-1:0]   prod_q[$];
    int                     ld_q[$];

    logic [N-1:0] ma [DIM][DIM];
    logic [N-1:0] mb [DIM][DIM];
    logic [N-1:0] ha [13][DIM];
    logic [N-1:0] hb [13][DIM];
    int checks = 0;
    int errors = 0;
    int exp_perf = 0;

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic model_write(input bit sel, input int row, input logic [DIM*N-1:0] data);
        for (int k = 0; k < DIM; k++) begin
            if (sel) mb[row][k] = data[k*N +: N];
            else     ma[row][k] = data[k*N +: N];
        end
    endtask

    // Reference: 20 busy cycles = CLEAR, FEED t=0..12, READ, SHIFT s=0..3, LAST; result is A*B mod 2^N.
    task automatic push_run();
        exp_t e;
        logic [DIM*DIM*N-1:0] p;
        logic [N-1:0] sum;
        for (int c = 0; c < 20; c++) begin
            e.c = c; e.done = 1'b0; e.a = '0; e.b = '0;
            e.clr = '0; e.rd = '0; e.wr = '0; e.rv = 1'b0; e.row = '0;
            if (c == 0) e.clr = '1;
            else if (c <= 13) begin
                for (int lane = 0; lane < DIM; lane++) begin
                    int d;
                    d = (c - 1) - lane;
                    if (d >= 0 && d < DIM) begin
                        e.a[lane*N +: N] = ma[lane][d];
                        e.b[lane*N +: N] = mb[d][lane];
                    end
                end
            end else if (c == 14) e.rd = '1;
            else begin
                e.rv  = 1'b1;
                e.row = 3'(19 - c);
                if (c < 19) e.wr = '1;
                else        e.done = 1'b1;
            end
            exp_q.push_back(e);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                sum = '0;
                for (int k = 0; k < DIM; k++) sum = sum + ma[i][k] * mb[k][j];
                p[(i*DIM+j)*N +: N] = sum;
            end
        prod_q.push_back(p);
        exp_perf++;
    endtask

    task automatic do_load(input bit sel, input int row, input logic [DIM*N-1:0] data, input bit in_run);
        ld_en = 1'b1; ld_sel = sel; ld_row = 3'(row); ld_data = data;
        if (in_run || row > 4) ld_q.push_back(1);
        else model_write(sel, row, data);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic do_start(input bit with_load, input bit sel, input int row, input logic [DIM*N-1:0] data);
        start = 1'b1;
        if (with_load) begin
            ld_en = 1'b1; ld_sel = sel; ld_row = 3'(row); ld_data = data;
            model_write(sel, row, data);
        end
        push_run();
        @(posedge clk); #1;
        start = 1'b0; ld_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        check("wait_idle", ok, $sformatf("timeout busy=%b pending=%0d", busy, exp_q.size()));
    endtask

    task automatic load_matrix(input bit sel, input int mode);
        logic [DIM*N-1:0] d;
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) begin
                case (mode)
                    0: d[k*N +: N] = (r == k) ? 32'd1 : 32'd0;
                    1: d[k*N +: N] = 32'(r*5 + k + 1);
                    2: d[k*N +: N] = 32'(10*r + k);
                    3: d[k*N +: N] = 32'd2;
                    4: d[k*N +: N] = 32'd3;
                    default: d[k*N +: N] = $urandom;
                endcase
            end
            do_load(sel, r, d, 1'b0);
        end
    endtask

    // Monitor: compares every busy cycle against the scoreboard and emulates the attached array.
    always @(negedge clk) begin : mon
        exp_t e;
        logic [DIM*DIM*N-1:0] p;
        logic [N-1:0] acc;
        bit ok;
        string det;
        if (clr_n) begin
            if (busy) begin
                if (exp_q.size() == 0) check("busy_unexpected", 1'b0, "busy=1 with no run pending");
                else begin
                    e = exp_q.pop_front();
                    ok = (done === e.done) && (a_out === e.a) && (b_out === e.b) && (pe_clr === e.clr)
                      && (pe_read === e.rd) && (pe_write === e.wr) && (res_valid === e.rv) && (res_row === e.row);
                    check($sformatf("cycle%0d", e.c), ok,
                          $sformatf("got a=%h b=%h clr=%h rd=%h wr=%h rv=%b row=%0d done=%b; want a=%h b=%h clr=%h rd=%h wr=%h rv=%b row=%0d done=%b",
                                    a_out, b_out, pe_clr, pe_read, pe_write, res_valid, res_row, done,
                                    e.a, e.b, e.clr, e.rd, e.wr, e.rv, e.row, e.done));
                    if (e.c >= 1 && e.c <= 13)
                        for (int l = 0; l < DIM; l++) begin
                            ha[e.c-1][l] = a_out[l*N +: N];
                            hb[e.c-1][l] = b_out[l*N +: N];
                        end
                    if (e.c == 19) begin
                        if (prod_q.size() == 0) check("product", 1'b0, "no expected product");
                        else begin
                            p = prod_q.pop_front();
                            ok = 1'b1; det = "";
                            for (int i = 0; i < DIM; i++)
                                for (int j = 0; j < DIM; j++) begin
                                    acc = '0;
                                    for (int t = 0; t < 25; t++)
                                        if (t - j >= 0 && t - j < 13 && t - i >= 0 && t - i < 13)
                                            acc = acc + ha[t-j][i] * hb[t-i][j];
                                    if (ok && acc !== p[(i*DIM+j)*N +: N]) begin
                                        ok = 1'b0;
                                        det = $sformatf("C[%0d][%0d] got %0d want %0d", i, j, acc, p[(i*DIM+j)*N +: N]);
                                    end
                                end
                            check("product", ok, det);
                        end
                    end
                end
            end else begin
                ok = !done && !res_valid && res_row == 0 && a_out == 0 && b_out == 0
                  && pe_clr == 0 && pe_read == 0 && pe_write == 0;
                check("idle_zero", ok, $sformatf("got done=%b rv=%b a=%h b=%h want all 0", done, res_valid, a_out, b_out));
            end
            if (ld_err) begin
                if (ld_q.size() == 0) check("ld_err", 1'b0, "unexpected ld_err pulse, want none");
                else begin
                    void'(ld_q.pop_front());
                    check("ld_err", 1'b1, "");
                end
            end
        end
    end

    initial begin
        logic [DIM*N-1:0] d;
        clr_n = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_row = '0; ld_data = '0; start = 1'b0;
        for (int i = 0; i < DIM; i++) for (int k = 0; k < DIM; k++) begin ma[i][k] = '0; mb[i][k] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, done, ld_err, res_valid, res_row, a_out, b_out, pe_clr, pe_read, pe_write} == '0,
              $sformatf("got busy=%b done=%b a=%h want all 0", busy, done, a_out));
        clr_n = 1'b1;
        @(posedge clk); #1;

        // Identity A, B rows {1..5}..{21..25}
        load_matrix(1'b0, 0);
        load_matrix(1'b1, 1);
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();

        // Skew pattern A[i][k]=10i+k
        load_matrix(1'b0, 2);
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();

        // All 2s times all 3s, twice back to back
        load_matrix(1'b0, 3);
        load_matrix(1'b1, 4);
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();

        // Protocol errors: bad row in IDLE, load and start during a run
        d = {DIM{32'hDEAD_BEEF}};
        do_load(1'b0, 5, d, 1'b0);
        do_load(1'b1, 7, d, 1'b0);
        do_start(1'b0, 1'b0, 0, '0);
        repeat (4) @(posedge clk);
        #1;
        do_load(1'b0, 1, d, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Load coinciding with start uses the new row
        d = '0;
        for (int k = 0; k < DIM; k++) d[k*N +: N] = 32'(100 + k);
        do_start(1'b1, 1'b1, 2, d);
        wait_idle();

        // Random matrices
        for (int r = 0; r < 4; r++) begin
            load_matrix(1'b0, 9);
            load_matrix(1'b1, 9);
            do_start(1'b0, 1'b0, 0, '0);
            wait_idle();
        end

`ifdef FEEDER_PERF_EN
        check("perf_cnt", perf_cnt == 16'(exp_perf), $sformatf("got %0d want %0d", perf_cnt, exp_perf));
`endif

        // Reset in the middle of FEED aborts immediately
        load_matrix(1'b0, 9);
        do_start(1'b0, 1'b0, 0, '0);
        repeat (5) @(posedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        check("reset_abort", {busy, done, ld_err, res_valid, res_row, a_out, b_out, pe_clr, pe_read, pe_write} == '0,
              $sformatf("got busy=%b a=%h b=%h pe_clr=%h want all 0", busy, a_out, b_out, pe_clr));
        exp_q.delete(); prod_q.delete(); ld_q.delete();
        exp_perf = 0;
        for (int i = 0; i < DIM; i++) for (int k = 0; k < DIM; k++) begin ma[i][k] = '0; mb[i][k] = '0; end
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        @(posedge clk); #1;
        check("busy_after_reset", busy == 1'b0, $sformatf("got %b want 0", busy));
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();
        load_matrix(1'b0, 9);
        load_matrix(1'b1, 3);
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();

`ifdef FEEDER_PERF_EN
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();
        check("perf_cnt3", perf_cnt == 16'd3, $sformatf("got %0d want 3", perf_cnt));
        force dut.perf_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.perf_cnt;
        do_start(1'b0, 1'b0, 0, '0);
        wait_idle();
        check("perf_sat", perf_cnt == 16'hFFFF, $sformatf("got %h want ffff", perf_cnt));
`endif

        repeat (2) @(posedge clk);
        #1;
        check("queues_drained", exp_q.size() == 0 && prod_q.size() == 0 && ld_q.size() == 0,
              $sformatf("got exp=%0d prod=%0d ld=%0d want 0", exp_q.size(), prod_q.size(), ld_q.size()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
